// File: rtl/soc_seg7_pkg.sv
// Shared constants for the seven-segment display blocks: active-low segment codes,
// blank patterns and the scan-counter width helper.
package soc_seg7_pkg;

  // Segment codes {g,f,e,d,c,b,a}, active-low, for hex digits 0..F.
  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Width of a counter that must hold 0..ticks-1; never narrower than one bit.
  function automatic int cnt_width(input int ticks);
    int w;
    w = $clog2(ticks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/soc_seg7_if.sv
// Display-side bundle: the word to show plus the multiplexed segment/anode drive.
interface soc_seg7_if;
  // No handshake: iREG32/iDP are level inputs sampled only on the frame snapshot
  // edge (unless iHOLD is high); the outputs are free-running registered drives.
  logic [31:0] iREG32;
  logic [7:0]  iDP;
  logic        iHOLD;
  logic [7:0]  oAN;
  logic [6:0]  oSEG;
  logic        oDP;

  modport master (
    output iREG32, iDP, iHOLD,
    input  oAN, oSEG, oDP
  );

  modport slave (
    input  iREG32, iDP, iHOLD,
    output oAN, oSEG, oDP
  );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment code {g,f,e,d,c,b,a}.
module seg7_hex_decoder
  import soc_seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/soc_seg7_display.sv
// 8-digit multiplexed hex display of a 32-bit word, snapshotted once per frame.
// Optional leading-zero suppression when SOC_SEG7_ZERO_BLANK_EN is defined.
module soc_seg7_display
  import soc_seg7_pkg::*;
#(
  parameter int DIGIT_TICKS = 50000
) (
  input  logic       iCLK,
  input  logic       iRST,
  soc_seg7_if.slave  disp
);

  localparam int            CW       = cnt_width(DIGIT_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_TICKS - 1);

  generate
    if (DIGIT_TICKS < 2) begin : g_bad_ticks
      $error("soc_seg7_display: DIGIT_TICKS must be 2 or more");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic [7:0]    dps;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic [31:0]   shifted;
  logic [3:0]    nib;
  logic [6:0]    seg_code;
  logic          lit;

  // shifted[3:0] is the current digit's nibble; the rest are the digits above it.
  assign shifted = shadow >> {idx, 2'b00};
  assign nib     = shifted[3:0];

  seg7_hex_decoder u_dec (
    .nibble (nib),
    .seg    (seg_code)
  );

`ifdef SOC_SEG7_ZERO_BLANK_EN
  // A digit is a leading zero when it and everything above it is zero.
  assign lit = (idx == 3'd0) || dps[idx] || (shifted != 32'd0);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt    <= '0;
      idx    <= 3'd0;
      shadow <= 32'd0;
      dps    <= 8'd0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Snapshot only on the blanked first cycle of the frame, so no lit digit tears.
      if ((cnt == '0) && (idx == 3'd0) && !disp.iHOLD) begin
        shadow <= disp.iREG32;
        dps    <= disp.iDP;
      end

      if ((cnt == '0) || !lit) begin
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= ~(8'h01 << idx);
        seg_q <= seg_code;
        dp_q  <= ~dps[idx];
      end
    end
  end

  assign disp.oAN  = an_q;
  assign disp.oSEG = seg_q;
  assign disp.oDP  = dp_q;

endmodule

// File: tb/tb_soc_seg7_display.sv
// Directed bench for soc_seg7_display with DIGIT_TICKS=4 (32-cycle frame).
// Expectations cover SOC_SEG7_ZERO_BLANK_EN when the bench is built with it defined.
module tb_soc_seg7_display;
  localparam int TICKS = 4;
  localparam int FRAME = 8 * TICKS;
  localparam int W     = 16;
  localparam logic [W-1:0] BLANK = {8'hFF, 7'h7F, 1'b1};

  // clock / reset
  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  soc_seg7_if bus ();

  soc_seg7_display #(.DIGIT_TICKS(TICKS)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .disp (bus.slave)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
               tag, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Expected outputs for one full frame starting at its snapshot edge.
  task automatic push_frame(input logic [31:0] v, input logic [7:0] dp);
    for (int k = 0; k < FRAME; k++) begin
      int d;
      logic [31:0] up;
      logic [3:0]  nib;
      logic        blank_digit;
      d   = k / TICKS;
      up  = v >> (4 * d);
      nib = up[3:0];
      blank_digit = 1'b0;
`ifdef SOC_SEG7_ZERO_BLANK_EN
      blank_digit = (d > 0) && (up == 32'd0) && !dp[d];
`endif
      if ((k % TICKS) == 0 || blank_digit)
        exp_q.push_back(BLANK);
      else
        exp_q.push_back({~(8'h01 << d), seg_tab[nib], ~dp[d]});
    end
  endtask

  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s[%0d]: expectation queue empty", tag, i);
      end else begin
        check_val($sformatf("%s[%0d]", tag, i), {bus.oAN, bus.oSEG, bus.oDP}, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    iRST       = 1'b1;
    bus.iREG32 = 32'hFFFF_FFFF;
    bus.iDP    = 8'h00;
    bus.iHOLD  = 1'b0;

    // reset holds everything blank
    for (int i = 0; i < 3; i++) begin
      step();
      check_val($sformatf("reset[%0d]", i), {bus.oAN, bus.oSEG, bus.oDP}, BLANK);
    end

    // full frame twice
    bus.iREG32 = 32'h0123_4567;
    iRST       = 1'b0;
    push_frame(32'h0123_4567, 8'h00);
    run_cycles(FRAME, "frame1");
    push_frame(32'h0123_4567, 8'h00);
    run_cycles(FRAME, "frame2");

    // mid-frame change invisible until the next frame
    push_frame(32'h0123_4567, 8'h00);
    run_cycles(13, "mid_a");
    bus.iREG32 = 32'h89AB_CDEF;
    run_cycles(FRAME - 13, "mid_b");
    push_frame(32'h89AB_CDEF, 8'h00);
    run_cycles(FRAME, "mid_new");

    // hold across a frame boundary freezes value and decimal points
    push_frame(32'h89AB_CDEF, 8'h00);
    run_cycles(30, "hold_a");
    bus.iHOLD  = 1'b1;
    bus.iREG32 = 32'h2468_ACE0;
    bus.iDP    = 8'h81;
    run_cycles(2, "hold_b");
    push_frame(32'h89AB_CDEF, 8'h00);
    run_cycles(FRAME - 1, "hold_c");
    bus.iHOLD = 1'b0;
    run_cycles(1, "hold_d");
    push_frame(32'h2468_ACE0, 8'h81);
    run_cycles(21, "hold_new");

    // reset during slot 5
    iRST       = 1'b1;
    bus.iREG32 = 32'h1357_9BDF;
    step();
    check_val("rst_mid", {bus.oAN, bus.oSEG, bus.oDP}, BLANK);
    exp_q.delete();
    iRST = 1'b0;
    push_frame(32'h1357_9BDF, 8'h81);
    run_cycles(FRAME, "after_rst");

    // leading zeros (suppressed only in the zero-blank build)
    bus.iREG32 = 32'h0000_00A5;
    bus.iDP    = 8'h00;
    push_frame(32'h0000_00A5, 8'h00);
    run_cycles(FRAME, "zb_a5");
    bus.iREG32 = 32'h0000_0000;
    push_frame(32'h0000_0000, 8'h00);
    run_cycles(FRAME, "zb_zero");
    bus.iDP = 8'h80;
    push_frame(32'h0000_0000, 8'h80);
    run_cycles(FRAME, "zb_dp7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
